// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// field widths, the pipeline control bundle and a register-match helper.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int WAIT_CNT_W = 10;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Canned control patterns; HOLD is also the safe value for INIT/ERR/reset.
    localparam ctrl_t CTRL_HOLD     = 7'b000_0000;
    localparam ctrl_t CTRL_NORMAL   = 7'b111_1100;
    localparam ctrl_t CTRL_BRANCH   = 7'b111_1111;
    localparam ctrl_t CTRL_LOAD_USE = 7'b001_1101;

    function automatic logic reg_match(
        input logic                 uses,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dst
    );
        reg_match = uses & (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between the load in EX and the
// instruction in ID. Register x0 never creates a hazard.
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic                 i_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    output logic                 o_load_use
);

    logic w_rd_nonzero;
    logic w_src_hit;

    assign w_rd_nonzero = (i_ex_rd != 5'd0);
    assign w_src_hit    = reg_match(i_id_uses_rs1, i_id_rs1, i_ex_rd)
                        | reg_match(i_id_uses_rs2, i_id_rs2, i_ex_rd);
    assign o_load_use   = i_ex_mem_read & w_rd_nonzero & w_src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze control with a data-memory
// timeout FSM. Optional performance counters under HAZARD_PERF_CNT_EN.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic                 i_ex_mem_read,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_branch_taken,
    input  logic                 i_dmem_req,
    input  logic                 i_dmem_ready,
    output logic                 o_pc_we,
    output logic                 o_ifid_we,
    output logic                 o_idex_we,
    output logic                 o_exmem_we,
    output logic                 o_memwb_we,
    output logic                 o_ifid_flush,
    output logic                 o_idex_flush,
    output logic                 o_mem_err,
    output logic [CNT_W-1:0]     o_stall_cnt,
    output logic [CNT_W-1:0]     o_flush_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_e                  r_state;
    state_e                  w_next_state;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_nxt;
    logic                    w_freeze;
    logic                    w_load_use;
    ctrl_t                   w_ctrl;

    assign w_freeze = i_dmem_req & ~i_dmem_ready;

    hazard_detect u_hazard_detect (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    // Next-state and wait-counter logic; the counter restarts on every WAIT entry.
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_INIT: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_freeze) begin
                    w_next_state   = ST_WAIT;
                    w_wait_cnt_nxt = {WAIT_CNT_W{1'b0}};
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (w_freeze) begin
                    if (r_wait_cnt == TIMEOUT_LAST) begin
                        w_next_state = ST_ERR;
                    end else begin
                        w_next_state   = ST_WAIT;
                        w_wait_cnt_nxt = r_wait_cnt + 10'd1;
                    end
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_wait_cnt <= {WAIT_CNT_W{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Pipeline control: freeze beats branch beats load-use; only RUN/WAIT ever enable.
    always_comb begin
        w_ctrl = CTRL_HOLD;
        case (r_state)
            ST_RUN, ST_WAIT: begin
                if (w_freeze) begin
                    w_ctrl = CTRL_HOLD;
                end else if (i_ex_branch_taken) begin
                    w_ctrl = CTRL_BRANCH;
                end else if (w_load_use) begin
                    w_ctrl = CTRL_LOAD_USE;
                end else begin
                    w_ctrl = CTRL_NORMAL;
                end
            end
            default: begin
                w_ctrl = CTRL_HOLD;
            end
        endcase
    end

    assign o_pc_we      = w_ctrl.pc_we;
    assign o_ifid_we    = w_ctrl.ifid_we;
    assign o_idex_we    = w_ctrl.idex_we;
    assign o_exmem_we   = w_ctrl.exmem_we;
    assign o_memwb_we   = w_ctrl.memwb_we;
    assign o_ifid_flush = w_ctrl.ifid_flush;
    assign o_idex_flush = w_ctrl.idex_flush;
    assign o_mem_err    = (r_state == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic             w_active;
    logic             w_stall_ev;
    logic             w_flush_ev;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // A load-use overridden by a taken branch is not a stall cycle.
    assign w_active   = (r_state == ST_RUN) | (r_state == ST_WAIT);
    assign w_stall_ev = w_active & (w_freeze | (w_load_use & ~i_ex_branch_taken));
    assign w_flush_ev = w_active & ~w_freeze & i_ex_branch_taken;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_ev && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_ev && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = {CNT_W{1'b0}};
    assign o_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic             dmem_req, dmem_ready;
    logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic             ifid_flush, idex_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       out_bits;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [6:0] O_HOLD = 7'b000_0000;
    localparam logic [6:0] O_NORM = 7'b111_1100;
    localparam logic [6:0] O_BR   = 7'b111_1111;
    localparam logic [6:0] O_LU   = 7'b001_1101;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_uses_rs1     (id_uses_rs1),
        .i_id_uses_rs2     (id_uses_rs2),
        .i_ex_mem_read     (ex_mem_read),
        .i_ex_rd           (ex_rd),
        .i_ex_branch_taken (ex_branch_taken),
        .i_dmem_req        (dmem_req),
        .i_dmem_ready      (dmem_ready),
        .o_pc_we           (pc_we),
        .o_ifid_we         (ifid_we),
        .o_idex_we         (idex_we),
        .o_exmem_we        (exmem_we),
        .o_memwb_we        (memwb_we),
        .o_ifid_flush      (ifid_flush),
        .o_idex_flush      (idex_flush),
        .o_mem_err         (mem_err),
        .o_stall_cnt       (stall_cnt),
        .o_flush_cnt       (flush_cnt)
    );

    assign out_bits = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush};

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic load_use_in();
        clear_in();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"normal",        5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM};
        vecs[1] = '{"lu_rs1",        5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_LU};
        vecs[2] = '{"lu_rd_zero",    5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM};
        vecs[3] = '{"lu_rs2",        5'd1,  5'd7,  1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_LU};
        vecs[4] = '{"rs1_not_used",  5'd9,  5'd0,  1'b0, 1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b0, O_NORM};
        vecs[5] = '{"not_load",      5'd9,  5'd9,  1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, O_NORM};
        vecs[6] = '{"branch_and_lu", 5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, O_BR};
        vecs[7] = '{"branch_only",   5'd3,  5'd4,  1'b1, 1'b1, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, O_BR};
        vecs[8] = '{"lu_mem_ready",  5'd12, 5'd0,  1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[9] = '{"lu_rd31_rs2",   5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, O_LU};

        // Reset and INIT
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out", 32'(out_bits), 32'(O_HOLD));
        check("reset_mem_err", 32'(mem_err), 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_out", 32'(out_bits), 32'(O_HOLD));

        // Table of single-cycle combinational vectors in RUN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear_in();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd;
            ex_branch_taken = vecs[i].br;
            dmem_req = vecs[i].req; dmem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, 32'(out_bits), 32'(vecs[i].exp));
            check({vecs[i].name, "_mem_err"}, 32'(mem_err), 32'd0);
        end

        // Freeze for three cycles, then the ready cycle proceeds normally
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_in();
            dmem_req = 1'b1;
            ex_branch_taken = (i == 1);
            #1;
            check("freeze_out", 32'(out_bits), 32'(O_HOLD));
        end
        @(negedge clk);
        clear_in();
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        check("freeze_ready_out", 32'(out_bits), 32'(O_NORM));
        @(negedge clk);
        clear_in();
        #1;
        check("after_freeze_out", 32'(out_bits), 32'(O_NORM));
        check("after_freeze_mem_err", 32'(mem_err), 32'd0);

        // Timeout: error only after the fifth frozen cycle
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            clear_in();
            dmem_req = 1'b1;
            #1;
            check($sformatf("timeout_mem_err_%0d", i), 32'(mem_err), (i == 6) ? 32'd1 : 32'd0);
            check($sformatf("timeout_out_%0d", i), 32'(out_bits), 32'(O_HOLD));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_in();
            dmem_req = 1'b1; dmem_ready = 1'b1;
            #1;
            check("err_sticky_mem_err", 32'(mem_err), 32'd1);
            check("err_sticky_out", 32'(out_bits), 32'(O_HOLD));
        end
        @(negedge clk);
        clear_in();
        rst_n = 1'b0;
        #1;
        check("err_reset_mem_err", 32'(mem_err), 32'd0);
        check("err_reset_out", 32'(out_bits), 32'(O_HOLD));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("err_reset_init_out", 32'(out_bits), 32'(O_HOLD));
        @(negedge clk);
        #1;
        check("err_reset_run_out", 32'(out_bits), 32'(O_NORM));

        // Reset asserted mid-WAIT
        @(negedge clk);
        dmem_req = 1'b1;
        @(negedge clk);
        #2;
        dmem_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("wait_reset_out", 32'(out_bits), 32'(O_HOLD));
        check("wait_reset_mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("wait_reset_init_out", 32'(out_bits), 32'(O_HOLD));
        @(negedge clk);
        #1;
        check("wait_reset_run_out", 32'(out_bits), 32'(O_NORM));

        // Counters: 2 load-use + 3 freeze + ready + 1 branch after a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            load_use_in();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_in();
            dmem_req = 1'b1;
        end
        @(negedge clk);
        clear_in();
        dmem_req = 1'b1; dmem_ready = 1'b1;
        @(negedge clk);
        clear_in();
        ex_branch_taken = 1'b1;
        #1;
        check("cnt_branch_out", 32'(out_bits), 32'(O_BR));
        @(negedge clk);
        clear_in();
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd5);
        check("flush_cnt", flush_cnt, 32'd1);
`else
        check("stall_cnt", stall_cnt, 32'd0);
        check("flush_cnt", flush_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
